// File: rtl/drac_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | drac_pkg: shared types and port indices for the L1.5 request arbiter.    |
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
package drac_pkg;

  typedef enum logic [0:0] {
    L15_ARB_IDLE = 1'b0,
    L15_ARB_REQ  = 1'b1
  } l15_arb_state_e;

  localparam int L15_ARB_PORTID_W = 2;
  typedef logic [L15_ARB_PORTID_W-1:0] req_portid_t;

  localparam int L15_ARB_AGE_W = 8;

  localparam req_portid_t L15_PORT_ICACHE      = 2'd0;
  localparam req_portid_t L15_PORT_DCACHE_READ  = 2'd1;
  localparam req_portid_t L15_PORT_DCACHE_WRITE = 2'd2;
  localparam req_portid_t L15_PORT_DCACHE_AMO   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/l15_arb_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | l15_arb_pick: find-first-set over a request vector, starting at offset_i |
// | and wrapping around. Revision: 1.0                                       |
// ----------------------------------------------------------------------------
module l15_arb_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] offset_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] cand;

  // Scan from the far end back toward the offset so the first hit wins last.
  always_comb begin
    found_o = |req_i;
    idx_o   = '0;
    cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = W'((int'(offset_i) + i) % N);
      if (req_i[cand]) idx_o = cand;
    end
  end

endmodule
`default_nettype wire

// File: rtl/l15_req_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | l15_req_port_arbiter: grants one core miss port at a time to the L1.5,   |
// | with credits and starvation aging. Option macro: L15_ARB_RR_EN.          |
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
module l15_req_port_arbiter
  import drac_pkg::*;
#(
  parameter int NumPorts       = 4,
  parameter int MaxOutstanding = 4,
  parameter int StarveTh       = 16,
  parameter int PortIdWidth    = $clog2(NumPorts)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumPorts-1:0]    req_valid_i,
  output logic [NumPorts-1:0]    req_ready_o,
  output logic                   l15_val_o,
  output logic [PortIdWidth-1:0] l15_portid_o,
  input  logic                   l15_ack_i,
  input  logic                   rtrn_valid_i,
  input  logic [PortIdWidth-1:0] rtrn_portid_i,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);

  l15_arb_state_e                          state_q, state_d;
  logic [PortIdWidth-1:0]                  portid_q, portid_d;
  logic [NumPorts-1:0][CntW-1:0]           cnt_q, cnt_d;
  logic [NumPorts-1:0][L15_ARB_AGE_W-1:0]  age_q, age_d;
  logic                                    err_q, err_d;

  logic [NumPorts-1:0]    eligible, urgent, granted, ack_hit, rtrn_hit;
  logic                   urg_found, nrm_found, ack_fire;
  logic [PortIdWidth-1:0] urg_idx, nrm_idx, rr_offset, winner;

  assign ack_fire = (state_q == L15_ARB_REQ) && l15_ack_i;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      eligible[p] = req_valid_i[p] && (cnt_q[p] < CntW'(MaxOutstanding));
      urgent[p]   = eligible[p] && (age_q[p] >= L15_ARB_AGE_W'(StarveTh));
      ack_hit[p]  = ack_fire && (portid_q == PortIdWidth'(p));
      rtrn_hit[p] = rtrn_valid_i && (rtrn_portid_i == PortIdWidth'(p));
    end
  end

`ifdef L15_ARB_RR_EN
  logic [PortIdWidth-1:0] last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = ack_fire ? portid_q : last_grant_q;
    rr_offset    = (last_grant_q == PortIdWidth'(NumPorts - 1)) ? '0 : last_grant_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_grant_q <= PortIdWidth'(NumPorts - 1);
    else       last_grant_q <= last_grant_d;
  end
`else
  assign rr_offset = '0;
`endif

  // Urgency always resolves by fixed priority, independent of round-robin.
  l15_arb_pick #(.N(NumPorts), .W(PortIdWidth)) u_pick_urgent (
    .req_i   (urgent),
    .offset_i('0),
    .found_o (urg_found),
    .idx_o   (urg_idx)
  );

  l15_arb_pick #(.N(NumPorts), .W(PortIdWidth)) u_pick_normal (
    .req_i   (eligible),
    .offset_i(rr_offset),
    .found_o (nrm_found),
    .idx_o   (nrm_idx)
  );

  assign winner = urg_found ? urg_idx : nrm_idx;

  always_comb begin
    state_d  = state_q;
    portid_d = portid_q;
    err_d    = err_q;
    granted  = '0;
    cnt_d    = cnt_q;
    age_d    = age_q;
    case (state_q)
      L15_ARB_IDLE: begin
        if (nrm_found) begin
          state_d          = L15_ARB_REQ;
          portid_d         = winner;
          granted[winner]  = 1'b1;
        end
      end
      L15_ARB_REQ: begin
        granted[portid_q] = 1'b1;
        if (l15_ack_i) state_d = L15_ARB_IDLE;
      end
      default: state_d = L15_ARB_IDLE;
    endcase

    for (int p = 0; p < NumPorts; p++) begin
      // A simultaneous ack and return on one port cancel out.
      if (ack_hit[p] && !rtrn_hit[p]) begin
        if (cnt_q[p] < CntW'(MaxOutstanding)) cnt_d[p] = cnt_q[p] + 1'b1;
      end else if (rtrn_hit[p] && !ack_hit[p]) begin
        if (cnt_q[p] == '0) err_d = 1'b1;
        else                cnt_d[p] = cnt_q[p] - 1'b1;
      end

      if (!req_valid_i[p] || ack_hit[p])
        age_d[p] = '0;
      else if (eligible[p] && !granted[p] && (age_q[p] != '1))
        age_d[p] = age_q[p] + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= L15_ARB_IDLE;
      portid_q <= '0;
      cnt_q    <= '0;
      age_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      portid_q <= portid_d;
      cnt_q    <= cnt_d;
      age_q    <= age_d;
      err_q    <= err_d;
    end
  end

  assign req_ready_o  = ack_hit;
  assign l15_val_o    = (state_q == L15_ARB_REQ);
  assign l15_portid_o = portid_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != L15_ARB_IDLE) || (|cnt_q);

endmodule
`default_nettype wire

// File: tb/tb_l15_req_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | tb_l15_req_port_arbiter: directed stimulus with a grant scoreboard.      |
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
module tb_l15_req_port_arbiter;
  localparam int NP = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [NP-1:0] req_valid_i = '0;
  logic [NP-1:0] req_ready_o;
  logic          l15_val_o;
  logic [1:0]    l15_portid_o;
  logic          l15_ack_i = 1'b0;
  logic          rtrn_valid_i = 1'b0;
  logic [1:0]    rtrn_portid_i = '0;
  logic          busy_o;
  logic          err_o;

  l15_req_port_arbiter dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .l15_val_o    (l15_val_o),
    .l15_portid_o (l15_portid_o),
    .l15_ack_i    (l15_ack_i),
    .rtrn_valid_i (rtrn_valid_i),
    .rtrn_portid_i(rtrn_portid_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int   total = 0;
  int   bad   = 0;
  int   exp_q[$];
  int   pend[NP];
  bit   auto_ack = 0, auto_rtrn = 0, rtrn_with_ack = 0, rt_req = 0;
  logic [1:0] rt_id = '0;
  int   mon_e;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the next expected grant.
  always @(negedge clk_i) begin
    if (!rst_i && (req_ready_o != '0)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_grant: ready=%b portid=%0d expected none", req_ready_o, l15_portid_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("grant_ready", int'(req_ready_o), 1 << mon_e);
        chk("grant_portid", int'(l15_portid_o), mon_e);
      end
    end
  end

  task automatic cycle();
    @(posedge clk_i); #1;
    l15_ack_i = auto_ack && l15_val_o;
    if (rtrn_with_ack && auto_ack && l15_val_o) begin
      rtrn_valid_i  = 1'b1;
      rtrn_portid_i = l15_portid_o;
    end else begin
      rtrn_valid_i  = rt_req;
      rtrn_portid_i = rt_id;
    end
    rt_req = 0;
    @(negedge clk_i);
    for (int p = 0; p < NP; p++) begin
      if (req_ready_o[p]) begin
        if (pend[p] > 0) pend[p]--;
        if (auto_rtrn) begin
          rt_req = 1;
          rt_id  = 2'(p);
        end
      end
    end
    for (int p = 0; p < NP; p++) req_valid_i[p] = (pend[p] > 0);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic apply();
    for (int p = 0; p < NP; p++) req_valid_i[p] = (pend[p] > 0);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      cycle();
      n++;
    end
    chk({name, "_leftover"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_rtrn(input int id);
    rt_req = 1;
    rt_id  = 2'(id);
    cycle();
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < NP; p++) pend[p] = 0;
    idle(2);
    chk("rst_val", l15_val_o, 0);
    chk("rst_portid", int'(l15_portid_o), 0);
    chk("rst_ready", int'(req_ready_o), 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;
    idle(1);

    // 1: ports 1 and 3 together, lowest index first
    auto_ack = 1; auto_rtrn = 1;
    pend[1] = 1; pend[3] = 1; apply();
    exp_q.push_back(1); exp_q.push_back(3);
    cycle();
    chk("t1_val_next_cycle", l15_val_o, 1);
    chk("t1_portid_first", int'(l15_portid_o), 1);
    drain("t1", 20);
    chk("t1_busy_inflight", busy_o, 1);
    idle(3);
    chk("t1_busy_clear", busy_o, 0);

    // 2: port 0 hogs, port 2 becomes urgent after 16 waiting cycles
    pend[0] = 9; pend[2] = 1; apply();
    repeat (8) exp_q.push_back(0);
    exp_q.push_back(2); exp_q.push_back(0);
    drain("t2", 60);
    idle(3);
    chk("t2_busy_clear", busy_o, 0);

    // 3: port 1 exhausts its credits, port 2 slips in
    auto_rtrn = 0;
    pend[1] = 5; pend[2] = 1; apply();
    exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1); exp_q.push_back(1);
    exp_q.push_back(2);
    drain("t3", 40);
    idle(4);
    chk("t3_port1_blocked", l15_val_o, 0);
    chk("t3_busy_credits", busy_o, 1);
    exp_q.push_back(1);
    do_rtrn(1);
    drain("t3_regrant", 10);
    idle(2);
    repeat (4) do_rtrn(1);
    do_rtrn(2);
    chk("t3_busy_all_returned", busy_o, 0);
    chk("t3_no_err", err_o, 0);

    // 4: same-cycle ack and return, then a return at zero count
    pend[0] = 2; apply();
    exp_q.push_back(0); exp_q.push_back(0);
    drain("t4_fill", 20);
    idle(2);
    rtrn_with_ack = 1;
    pend[0] = 1; apply();
    exp_q.push_back(0);
    drain("t4_ackrtrn", 10);
    idle(2);
    rtrn_with_ack = 0;
    do_rtrn(0);
    chk("t4_cnt_after_one_rtrn", busy_o, 1);
    do_rtrn(0);
    chk("t4_cnt_after_two_rtrn", busy_o, 0);
    chk("t4_err_before", err_o, 0);
    do_rtrn(3);
    chk("t4_err_set", err_o, 1);
    idle(3);
    chk("t4_err_sticky", err_o, 1);

    // 5: reset during an unacknowledged request
    auto_ack = 0; auto_rtrn = 1;
    pend[2] = 1; apply();
    cycle();
    chk("t5_val_before_rst", l15_val_o, 1);
    chk("t5_portid_before_rst", int'(l15_portid_o), 2);
    rst_i = 1'b1;
    #1;
    chk("t5_val_in_rst", l15_val_o, 0);
    chk("t5_busy_in_rst", busy_o, 0);
    chk("t5_err_in_rst", err_o, 0);
    idle(2);
    rst_i = 1'b0;
    auto_ack = 1;
    exp_q.push_back(2);
    drain("t5_rearb", 10);
    idle(3);
    chk("t5_busy_clear", busy_o, 0);

    // 6: all ports valid, always acked
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    pend[0] = 3; pend[1] = 1; pend[2] = 1; pend[3] = 1; apply();
`ifdef L15_ARB_RR_EN
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(0);
`else
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
`endif
    drain("t6", 40);
    idle(3);
    chk("t6_busy_clear", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
